memory_sequencer_param: RTL
===========================

Name: memory_sequencer_param

Overview:
- Parametrised successor to the fixed 4-core memory control unit state machine.
- Sequences shared single-port data-memory access among up to MAX_CORES matrix-multiply cores.
- Drives the address mux select, write-data mux select, per-core read-data capture enables and the memory write enable.
- Sits between the core array and the shared data RAM. Adds reset, busy/done handshake, latched core count and broadcast read for any core count.

Parameters:
- MAX_CORES, 4, maximum number of cores served; must be >= 2.
- SEL_W, $clog2(MAX_CORES), width of mux select outputs; derived, not overridden.
- CNT_W, $clog2(MAX_CORES+1), width of the noc input.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous reset, active low.
- read_req  input  1  read request, sampled only in IDLE.
- read_diff  input  1  1 = each core reads its own address; 0 = one shared address broadcast to all cores.
- write_req  input  1  write request, sampled only in IDLE; priority over read_req.
- write_diff  input  1  1 = each core writes its own address/data; 0 = single write from core 0.
- noc  input  CNT_W  number of active cores; latched at acceptance.
- addr_sel  output  SEL_W  address mux select (core index).
- data_in_sel  output  SEL_W  write-data mux select (core index).
- data_out_en  output  MAX_CORES  one-hot or broadcast read-data capture enables.
- mem_we  output  1  memory write enable.
- busy  output  1  high while a multi-slot sequence is in progress.
- done  output  1  single-cycle pulse on the final slot of every accepted request.

Behaviour:
- All outputs are registered. Reset values (rst_n=0 at a clk edge): state=IDLE, idx=0, addr_sel=0, data_in_sel=0, data_out_en=0, mem_we=0, busy=0, done=0.
- Reset takes effect mid-sequence: the sequence is abandoned, no done pulse is issued, and the next cycle is IDLE.
- States: IDLE, RD_SEQ, WR_SEQ.
- Effective count: n_eff = noc clamped to [1, MAX_CORES]. noc=0 is treated as 1; noc>MAX_CORES is treated as MAX_CORES.
- n_eff, the op type and the diff bit are latched at acceptance; later input changes are ignored until IDLE is re-entered.
- Acceptance in IDLE: if write_req, accept a write; else if read_req, accept a read; else hold IDLE with all outputs 0.
- Slot 0 outputs appear the cycle after the accepting edge. Slot i occupies cycle i+1 after acceptance.
- Slot i output rules:
  - addr_sel = data_in_sel = i.
  - Read: data_out_en = one-hot bit i.
  - Write: mem_we = 1, data_out_en = 0.
- Shared read (read_diff=0): a single slot with addr_sel=0 and data_out_en bits [n_eff-1:0] all 1, the rest 0.
- Shared write (write_diff=0): a single slot with core 0, mem_we=1.
- Diff with n_eff=1: a single slot, identical to slot 0.
- Multi-slot (diff=1, n_eff>1): go to RD_SEQ or WR_SEQ with idx=0 and busy=1. Each edge increments idx and presents slot idx. The slot where idx==n_eff-1 has done=1 and busy=0, and the next edge returns to IDLE.
- Single-slot ops: the slot cycle has done=1 and busy=0, and the FSM stays in IDLE. A new request may be accepted on the same edge that presents that slot, giving back-to-back ops.
- Multi-slot ops: requests are ignored while busy=1. They are not queued; the requester holds the request until done is seen.
- Latency: request to first memory slot = 1 cycle. Total duration = n_eff cycles (diff) or 1 cycle (shared).
- During the last slot of a multi-slot op the FSM is already committed to IDLE. Requests present on that edge are not accepted; the earliest acceptance is the following edge.

Decomposition:
- Package mem_seq_pkg holds:
  - the state enum (IDLE, RD_SEQ, WR_SEQ);
  - a function clamp_noc(noc, MAX_CORES) returning n_eff;
  - a function onehot(idx) returning the MAX_CORES-wide one-hot vector;
  - a function lowmask(n) returning the broadcast mask.
- Single module; no sub-module is needed.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with write_req=1 -> all outputs 0 and busy=0; release -> the write is accepted on the next edge.
- Diff read, MAX_CORES=4, noc=4 -> 4 consecutive cycles with addr_sel 0,1,2,3 and data_out_en 0001,0010,0100,1000; done on the 4th cycle; busy high on cycles 1-3.
- Shared read, noc=3 -> 1 cycle with addr_sel=0, data_out_en=0111, done=1; diff write with noc=2 -> mem_we=1 for 2 cycles, data_in_sel 0 then 1.
- write_req and read_req both high with diff=1, noc=2 -> write sequence (mem_we=1, data_out_en=0 for 2 cycles); the read is then accepted after IDLE, beginning 2 cycles after done.
- noc=0 -> treated as 1 (a single slot); noc=7 with MAX_CORES=4 -> 4 slots. Changing noc from 4 to 2 mid-sequence still yields 4 slots.
- Assert rst_n=0 during slot 2 of a 4-core diff read -> no done pulse, outputs 0 the next cycle, and a fresh read is accepted after release.

Source files
------------

// File: rtl/mem_seq_pkg.sv
// Shared types and helpers for the parametrised shared-memory sequencer.
package mem_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_SEQ = 2'd1,
    WR_SEQ = 2'd2
  } state_t;

  // Masks are built at a fixed generous width; the sequencer keeps the low MAX_CORES bits.
  localparam int unsigned MASK_W = 32;
  typedef logic [MASK_W-1:0] mask_t;

  function automatic int unsigned clamp_noc(input int unsigned noc,
                                            input int unsigned max_cores);
    if (noc == 0) return 1;
    if (noc > max_cores) return max_cores;
    return noc;
  endfunction

  function automatic mask_t onehot(input int unsigned idx);
    return mask_t'(1) << idx;
  endfunction

  function automatic mask_t lowmask(input int unsigned n);
    mask_t m;
    m = '0;
    for (int unsigned i = 0; i < MASK_W; i++) m[i] = (i < n);
    return m;
  endfunction

endpackage

// File: rtl/memory_sequencer_param.sv
// Sequences shared single-port data-memory access among up to MAX_CORES cores,
// one core slot per cycle for per-core ops, or a single broadcast/shared slot.
module memory_sequencer_param
  import mem_seq_pkg::*;
#(
  parameter int MAX_CORES = 4,
  parameter int SEL_W     = $clog2(MAX_CORES),
  parameter int CNT_W     = $clog2(MAX_CORES + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 read_req,
  input  logic                 read_diff,
  input  logic                 write_req,
  input  logic                 write_diff,
  input  logic [CNT_W-1:0]     noc,
  output logic [SEL_W-1:0]     addr_sel,
  output logic [SEL_W-1:0]     data_in_sel,
  output logic [MAX_CORES-1:0] data_out_en,
  output logic                 mem_we,
  output logic                 busy,
  output logic                 done
);

  state_t                 state, state_d;
  logic [SEL_W-1:0]       idx, idx_d;
  logic [SEL_W-1:0]       n_last, n_last_d;   // n_eff-1 latched at acceptance
  logic [SEL_W-1:0]       slot;
  logic [SEL_W-1:0]       addr_sel_d, data_in_sel_d;
  logic [MAX_CORES-1:0]   data_out_en_d;
  logic                   mem_we_d, busy_d, done_d;
  logic                   req_diff;
  int unsigned            n_eff;

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d       = state;
    idx_d         = idx;
    n_last_d      = n_last;
    addr_sel_d    = '0;
    data_in_sel_d = '0;
    data_out_en_d = '0;
    mem_we_d      = 1'b0;
    busy_d        = 1'b0;
    done_d        = 1'b0;
    slot          = '0;
    n_eff         = clamp_noc(32'(noc), MAX_CORES);
    req_diff      = write_req ? write_diff : read_diff;

    case (state)
      IDLE: begin
        if (write_req || read_req) begin
          // Slot 0 is presented right away; only per-core ops over several cores need a sequence.
          mem_we_d = write_req;
          if (!write_req)
            data_out_en_d = req_diff ? MAX_CORES'(onehot(0)) : MAX_CORES'(lowmask(n_eff));
          if (req_diff && n_eff > 1) begin
            state_d  = write_req ? WR_SEQ : RD_SEQ;
            idx_d    = '0;
            n_last_d = SEL_W'(n_eff - 1);
            busy_d   = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      RD_SEQ, WR_SEQ: begin
        if (idx == n_last) begin
          // Last slot already shown; return to IDLE with outputs quiet and requests ignored.
          state_d = IDLE;
        end else begin
          slot          = idx + SEL_W'(1);
          idx_d         = slot;
          addr_sel_d    = slot;
          data_in_sel_d = slot;
          mem_we_d      = (state == WR_SEQ);
          if (state == RD_SEQ) data_out_en_d = MAX_CORES'(onehot(32'(slot)));
          done_d        = (slot == n_last);
          busy_d        = (slot != n_last);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      n_last      <= '0;
      addr_sel    <= '0;
      data_in_sel <= '0;
      data_out_en <= '0;
      mem_we      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_d;
      idx         <= idx_d;
      n_last      <= n_last_d;
      addr_sel    <= addr_sel_d;
      data_in_sel <= data_in_sel_d;
      data_out_en <= data_out_en_d;
      mem_we      <= mem_we_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

endmodule
